page_fetch: RTL and testbench

//   Pixel-data source for vga_control: turns its 17-bit frame address (320x240, 2x upscaled) into
//   a page-relative ROM address, returns 12-bit RGB as qsig. Owns comic page selection: debounced

---
 rtl/page_pkg.sv | 10 +
 rtl/page_fetch_btn_debounce.sv | 42 ++++
 rtl/page_fetch.sv | 153 +++++++++++++++
 tb/tb_page_fetch.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/page_pkg.sv
// Shared types and defaults for the page_fetch pixel source.
package page_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PEND, S_COMMIT} state_t;
  typedef enum logic {DIR_NEXT, DIR_PREV} dir_t;

  localparam int PAGES_DEF       = 8;
  localparam int FRAME_WORDS_DEF = 76800;
  localparam int RGB_W           = 12;
  localparam int FADDR_W         = 17;
endpackage

// File: rtl/page_fetch_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-time counter, one-cycle press pulse
// on the debounced 0->1 edge. Releases produce no pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // A sample equal to the current level is a change back, so reloading there
  // covers every bounce of a two-level input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync[1];
          cnt   <= '0;
          press <= sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/page_fetch.sv
// Comic page pixel source: frame address -> page ROM address -> RGB, 3-cycle fixed latency.
// Page changes commit on a VSync falling edge. `PAGE_FETCH_AUTO_FLIP_EN adds timed auto-advance.
module page_fetch
  import page_pkg::*;
#(
  parameter int PAGES       = PAGES_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_W      = 20,
  parameter int DEB_CYCLES  = 250000,
  parameter int AUTO_FRAMES = 300
) (
  input  logic                     clk_25mhz,
  input  logic                     sys_rst,
  input  logic [FADDR_W-1:0]       address_sig,
  input  logic                     VSync,
  input  logic                     btn_next,
  input  logic                     btn_prev,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [RGB_W-1:0]         rom_q,
  output logic [RGB_W-1:0]         qsig,
  output logic [$clog2(PAGES)-1:0] page_idx
);
  localparam int IDX_W = $clog2(PAGES);
  localparam logic [ADDR_W-1:0] FW_A      = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((PAGES - 1) * FRAME_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PAGES - 1);

  state_t            state, state_nx;
  dir_t              dir, dir_nx;
  logic [ADDR_W-1:0] page_base;
  logic              press_n, press_p, one_press;
  dir_t              press_dir;
  logic [1:0]        vs_q;
  logic              vs_edge;
  logic              auto_req;
  logic              in_range;
  logic [1:0]        oor_pipe;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clk_25mhz), .rst(sys_rst), .btn(btn_next), .press(press_n));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .clk(clk_25mhz), .rst(sys_rst), .btn(btn_prev), .press(press_p));

  assign one_press = press_n ^ press_p;
  assign press_dir = press_n ? DIR_NEXT : DIR_PREV;
  assign vs_edge   = vs_q[1] & ~vs_q[0];

  // VSync idles high, so reset to 1s to avoid a phantom edge after reset.
  always_ff @(posedge clk_25mhz or posedge sys_rst) begin
    if (sys_rst) vs_q <= 2'b11;
    else         vs_q <= {vs_q[0], VSync};
  end

`ifdef PAGE_FETCH_AUTO_FLIP_EN
  localparam int FC_W = $clog2(AUTO_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(AUTO_FRAMES);
  logic [FC_W-1:0] fcnt;

  assign auto_req = (state == S_IDLE) && (fcnt >= FC_MAX);

  always_ff @(posedge clk_25mhz or posedge sys_rst) begin
    if (sys_rst)                  fcnt <= '0;
    else if (press_n || press_p)  fcnt <= '0;
    else if (auto_req)            fcnt <= '0;
    else if (vs_edge && fcnt < FC_MAX) fcnt <= fcnt + 1'b1;
  end
`else
  // Never true for a legal AUTO_FRAMES; the frame counter is compiled out.
  assign auto_req = (AUTO_FRAMES < 1);
`endif

  always_ff @(posedge clk_25mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
      dir   <= DIR_NEXT;
    end else begin
      state <= state_nx;
      dir   <= dir_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    case (state)
      S_IDLE: begin
        if (one_press) begin
          state_nx = S_PEND;
          dir_nx   = press_dir;
        end else if (auto_req) begin
          state_nx = S_PEND;
          dir_nx   = DIR_NEXT;
        end
      end
      S_PEND: begin
        if ((press_n && dir == DIR_PREV) || (press_p && dir == DIR_NEXT))
          state_nx = S_IDLE;
        else if (vs_edge)
          state_nx = S_COMMIT;
      end
      S_COMMIT: begin
        if (one_press) begin
          state_nx = S_PEND;
          dir_nx   = press_dir;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Base tracks page_idx*FRAME_WORDS by stepping, so no multiplier is needed.
  always_ff @(posedge clk_25mhz or posedge sys_rst) begin
    if (sys_rst) begin
      page_idx  <= '0;
      page_base <= '0;
    end else if (state == S_COMMIT) begin
      if (dir == DIR_NEXT) begin
        if (page_idx == LAST_IDX) begin
          page_idx  <= '0;
          page_base <= '0;
        end else begin
          page_idx  <= page_idx + 1'b1;
          page_base <= page_base + FW_A;
        end
      end else begin
        if (page_idx == '0) begin
          page_idx  <= LAST_IDX;
          page_base <= LAST_BASE;
        end else begin
          page_idx  <= page_idx - 1'b1;
          page_base <= page_base - FW_A;
        end
      end
    end
  end

  assign in_range = ADDR_W'(address_sig) < FW_A;

  // Out-of-range flag rides alongside the ROM access to blank the pixel.
  always_ff @(posedge clk_25mhz or posedge sys_rst) begin
    if (sys_rst) begin
      rom_addr <= '0;
      oor_pipe <= 2'b00;
      qsig     <= '0;
    end else begin
      rom_addr <= page_base + (in_range ? ADDR_W'(address_sig) : '0);
      oor_pipe <= {oor_pipe[0], ~in_range};
      qsig     <= oor_pipe[1] ? '0 : rom_q;
    end
  end
endmodule

// File: tb/tb_page_fetch.sv
// Randomised bench for page_fetch against a page/request-level reference model.
module tb_page_fetch;
  localparam int P  = 3;
  localparam int FW = 16;
  localparam int AW = 20;
  localparam int DC = 4;
  localparam int AF = 2;

  logic          clk_25mhz = 1'b0;
  logic          sys_rst;
  logic [16:0]   address_sig;
  logic          VSync;
  logic          btn_next, btn_prev;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_q;
  logic [11:0]   qsig;
  logic [1:0]    page_idx;

  logic [11:0] rom_data [0:63];

  int checks = 0;
  int errors = 0;

  int m_page, m_pend, m_dir, m_cnt;
  int hist[$];

  page_fetch #(.PAGES(P), .FRAME_WORDS(FW), .ADDR_W(AW), .DEB_CYCLES(DC), .AUTO_FRAMES(AF)) dut (
    .clk_25mhz(clk_25mhz), .sys_rst(sys_rst), .address_sig(address_sig), .VSync(VSync),
    .btn_next(btn_next), .btn_prev(btn_prev), .rom_addr(rom_addr), .rom_q(rom_q),
    .qsig(qsig), .page_idx(page_idx));

  always #5 clk_25mhz = ~clk_25mhz;

  always @(posedge clk_25mhz) rom_q <= rom_data[rom_addr[5:0]];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int exp_ra(input int a);
    return m_page * FW + ((a < FW) ? a : 0);
  endfunction

  function automatic logic [11:0] exp_q(input int a);
    if (a >= FW) return 12'h000;
    return rom_data[exp_ra(a) % 64];
  endfunction

  task automatic model_reset();
    m_page = 0; m_pend = 0; m_dir = 0; m_cnt = 0;
  endtask

  task automatic model_press(input int d);
    m_cnt = 0;
    if (m_pend == 0) begin
      m_pend = 1; m_dir = d;
    end else if (m_dir != d) begin
      m_pend = 0;
    end
  endtask

  task automatic model_vsync();
    if (m_pend != 0) begin
      m_page = (m_dir == 0) ? (m_page + 1) % P : (m_page + P - 1) % P;
      m_pend = 0;
    end
`ifdef PAGE_FETCH_AUTO_FLIP_EN
    if (m_cnt < AF) m_cnt++;
    if (m_cnt >= AF) begin
      m_pend = 1; m_dir = 0; m_cnt = 0;
    end
`endif
  endtask

  task automatic press_btn(input int d, input int hold);
    @(negedge clk_25mhz);
    if (d == 0) btn_next = 1'b1; else btn_prev = 1'b1;
    repeat (hold) @(negedge clk_25mhz);
    btn_next = 1'b0; btn_prev = 1'b0;
    repeat (10) @(negedge clk_25mhz);
    if (hold >= DC + 2) model_press(d);
  endtask

  task automatic vsync_pulse();
    @(negedge clk_25mhz);
    VSync = 1'b0;
    repeat (4) @(negedge clk_25mhz);
    VSync = 1'b1;
    repeat (3) @(negedge clk_25mhz);
    model_vsync();
  endtask

  task automatic check_page(input string name);
    checks++;
    if (page_idx !== 2'(m_page)) begin
      errors++;
      $display("FAIL %s: page_idx=%0d expected %0d", name, page_idx, m_page);
    end
  endtask

  task automatic run_stream(input int n);
    int a;
    hist.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk_25mhz);
      if (hist.size() >= 1) begin
        checks++;
        if (rom_addr !== AW'(exp_ra(hist[hist.size()-1]))) begin
          errors++;
          $display("FAIL stream_rom_addr: addr_sig=%0d rom_addr=%0d expected %0d",
                   hist[hist.size()-1], rom_addr, exp_ra(hist[hist.size()-1]));
        end
      end
      if (hist.size() >= 3) begin
        checks++;
        if (qsig !== exp_q(hist[hist.size()-3])) begin
          errors++;
          $display("FAIL stream_qsig: addr_sig=%0d qsig=%h expected %h",
                   hist[hist.size()-3], qsig, exp_q(hist[hist.size()-3]));
        end
      end
      a = $urandom_range(0, 23);
      address_sig = 17'(a);
      hist.push_back(a);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge clk_25mhz);
    checks++;
    if (rom_addr !== '0 || qsig !== '0 || page_idx !== '0) begin
      errors++;
      $display("FAIL reset: rom_addr=%0d qsig=%h page_idx=%0d expected 0/0/0", rom_addr, qsig, page_idx);
    end
    sys_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    @(negedge clk_25mhz);
    address_sig = 17'd5;
    @(negedge clk_25mhz);
    checks++;
    if (rom_addr !== AW'(5)) begin
      errors++;
      $display("FAIL basic_rom_addr: got %0d expected 5", rom_addr);
    end
    repeat (2) @(negedge clk_25mhz);
    checks++;
    if (qsig !== 12'hABC) begin
      errors++;
      $display("FAIL basic_qsig: got %h expected abc", qsig);
    end
    run_stream(30);
  endtask

  task automatic test_next();
    press_btn(0, 6);
    check_page("next_before_vsync");
    run_stream(8);
    vsync_pulse();
    check_page("next_after_vsync");
    run_stream(12);
    press_btn(0, 2);
    vsync_pulse();
    check_page("glitch_ignored");
    run_stream(8);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6 && m_page != P - 1; i++) begin
      press_btn(0, 6);
      vsync_pulse();
    end
    check_page("reach_last");
    press_btn(0, 6);
    vsync_pulse();
    check_page("wrap_next");
    run_stream(10);
    for (int i = 0; i < 6 && m_page != 0; i++) begin
      press_btn(0, 6);
      vsync_pulse();
    end
    press_btn(1, 6);
    vsync_pulse();
    check_page("wrap_prev");
    run_stream(10);
  endtask

  task automatic test_cancel();
    press_btn(0, 6);
    press_btn(1, 6);
    vsync_pulse();
    check_page("cancel");
    run_stream(6);
    press_btn(0, 6);
    press_btn(0, 6);
    vsync_pulse();
    check_page("double_next");
    run_stream(6);
  endtask

  task automatic test_range_reset();
    @(negedge clk_25mhz);
    address_sig = 17'd20;
    repeat (3) @(negedge clk_25mhz);
    checks++;
    if (qsig !== 12'h000 || rom_addr !== AW'(m_page * FW)) begin
      errors++;
      $display("FAIL out_of_range: qsig=%h rom_addr=%0d expected 000/%0d", qsig, rom_addr, m_page * FW);
    end
    press_btn(0, 6);
    @(negedge clk_25mhz);
    sys_rst = 1'b1;
    @(negedge clk_25mhz);
    sys_rst = 1'b0;
    model_reset();
    check_page("reset_in_pend");
    vsync_pulse();
    check_page("vsync_after_reset");
    run_stream(10);
  endtask

  task automatic test_auto();
    for (int i = 0; i < 3; i++) begin
      vsync_pulse();
      check_page("auto_flip");
    end
    run_stream(8);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom_data[i] = 12'($urandom);
    rom_data[5] = 12'hABC;
    sys_rst = 1'b1;
    address_sig = '0;
    VSync = 1'b1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    test_reset();
    test_basic();
    test_next();
    test_wrap();
    test_cancel();
    test_range_reset();
    test_auto();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
